// File: rtl/axis_sample_pacer.sv
// -----------------------------------------------------------------------------
// axis_sample_pacer
//
// AXI4-Stream master that replays a preloaded block of signed samples at a
// fixed rate of one sample every clk_div system clocks. Samples are loaded
// through a simple write port while idle. A replay runs once or repeats until
// reset. The design respects downstream backpressure and counts sample ticks
// that were missed because of it.
//
// Parameters
//   data_width : sample width (two's complement)
//   depth      : sample RAM entries (power of two)
//   clk_div    : clocks per sample period (2..65535)
//
// Ports
//   clk, rst_n          : system clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data : load port, honoured only while idle
//   start               : begin a replay (sampled in IDLE)
//   loop_en             : wrap to index 0 after the last sample
//   num_samples         : samples per pass, 1..depth, captured at start
//   m_axis_tdata/tvalid/tready/tlast : AXI4-Stream master
//   busy                : replay in progress
//   done                : one-cycle pulse after a one-shot pass completes
//   overrun_cnt         : saturating count of ticks lost to backpressure
// -----------------------------------------------------------------------------
module axis_sample_pacer #(
  parameter  int data_width = 16,
  parameter  int depth      = 1024,
  parameter  int clk_div    = 5,
  localparam int addr_w     = $clog2(depth)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [addr_w-1:0]     wr_addr,
  input  logic [data_width-1:0] wr_data,
  input  logic                  start,
  input  logic                  loop_en,
  input  logic [addr_w:0]       num_samples,
  output logic [data_width-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           overrun_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  localparam logic [15:0]     tick_last = 16'(clk_div - 1);
  localparam logic [addr_w:0] depth_w   = (addr_w + 1)'(depth);

  state_t                  state, state_d;
  logic [15:0]             tick_cnt;
  logic [addr_w-1:0]       index, index_d;
  logic [addr_w:0]         num_cap;
  logic                    loop_cap;
  logic [data_width-1:0]   mem [depth];
  logic [data_width-1:0]   ram_q;

  logic start_ok;
  logic tick;
  logic hs;
  logic at_last;

  assign start_ok = (state == IDLE) && start &&
                    (num_samples != '0) && (num_samples <= depth_w);
  assign tick     = (state == RUN) && (tick_cnt == tick_last);
  assign hs       = m_axis_tvalid && m_axis_tready;
  assign at_last  = ({1'b0, index} == (num_cap - (addr_w + 1)'(1)));
  assign busy     = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and next-index logic. The RAM is addressed with the *next*
  // index so that ram_q always holds mem[index] during the current cycle,
  // which hides the one-cycle read latency from the port timing.
  // NOTE: every signal assigned in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state;
    index_d = index;
    unique case (state)
      IDLE: begin
        if (start_ok) begin
          state_d = RUN;
          index_d = '0;
        end
      end
      RUN: begin
        if (hs) begin
          if (at_last) begin
            index_d = '0;
            if (!loop_cap) state_d = FINISH;
          end else begin
            index_d = index + addr_w'(1);
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the sample RAM has no reset; its contents are undefined after
  // reset and a reset branch would prevent block-RAM inference.
  always_ff @(posedge clk) begin
    if (wr_en && (state == IDLE)) mem[wr_addr] <= wr_data;
    ram_q <= mem[index_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt      <= '0;
      index         <= '0;
      num_cap       <= '0;
      loop_cap      <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      done          <= 1'b0;
      overrun_cnt   <= '0;
    end else begin
      index <= index_d;
      // done trails the FINISH state by one cycle, landing in IDLE.
      done  <= (state == FINISH);

      if (start_ok) begin
        tick_cnt    <= '0;
        num_cap     <= num_samples;
        loop_cap    <= loop_en;
        overrun_cnt <= '0;
      end else if (state == RUN) begin
        // Free-running sample grid: backpressure never re-phases it.
        tick_cnt <= tick ? '0 : tick_cnt + 16'd1;
      end

      // A tick only launches a sample when nothing is outstanding; a tick
      // that finds the previous sample still held is dropped, not queued.
      if (tick && !m_axis_tvalid) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= ram_q;
        m_axis_tlast  <= at_last;
      end else if (hs) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end

      if (tick && m_axis_tvalid && !m_axis_tready && (overrun_cnt != 16'hFFFF)) begin
        overrun_cnt <= overrun_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_axis_sample_pacer.sv
// -----------------------------------------------------------------------------
// tb_axis_sample_pacer
//
// Directed bench for axis_sample_pacer. Two instances share the load port and
// tready: dut5 uses clk_div=5, dut2 uses clk_div=2 for the full-depth replay.
// Expected samples follow from the values each step loads.
// -----------------------------------------------------------------------------
module tb_axis_sample_pacer;

  localparam int dw = 16;
  localparam int dep = 1024;
  localparam int aw = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [aw-1:0] wr_addr = '0;
  logic [dw-1:0] wr_data = '0;
  logic          start5 = 1'b0;
  logic          start2 = 1'b0;
  logic          loop_en = 1'b0;
  logic          tready = 1'b0;
  logic [aw:0]   num_samples = '0;

  logic [dw-1:0] tdata5, tdata2;
  logic          tvalid5, tvalid2, tlast5, tlast2;
  logic          busy5, busy2, done5, done2;
  logic [15:0]   ovr5, ovr2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axis_sample_pacer #(.data_width(dw), .depth(dep), .clk_div(5)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start5), .loop_en(loop_en), .num_samples(num_samples),
    .m_axis_tdata(tdata5), .m_axis_tvalid(tvalid5),
    .m_axis_tready(tready), .m_axis_tlast(tlast5),
    .busy(busy5), .done(done5), .overrun_cnt(ovr5)
  );

  axis_sample_pacer #(.data_width(dw), .depth(dep), .clk_div(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start2), .loop_en(loop_en), .num_samples(num_samples),
    .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2),
    .m_axis_tready(tready), .m_axis_tlast(tlast2),
    .busy(busy2), .done(done2), .overrun_cnt(ovr2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [aw-1:0] a, input logic [dw-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  // Steps until the selected instance shows tvalid, at most budget cycles.
  task automatic wait_valid(input bit sel, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(sel ? tvalid2 : tvalid5) && (n < budget));
    check("wait tvalid", sel ? tvalid2 : tvalid5, 1);
  endtask

  task automatic expect_sample(input bit sel, input string tag, input logic [dw-1:0] d,
                               input bit last, input int period);
    int n;
    wait_valid(sel, period + 8, n);
    check({tag, " period"}, n, period);
    check({tag, " tdata"}, sel ? tdata2 : tdata5, d);
    check({tag, " tlast"}, sel ? tlast2 : tlast5, last);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset state ----------------
    repeat (3) step();
    check("rst tvalid", tvalid5, 0);
    check("rst tdata", tdata5, 0);
    check("rst tlast", tlast5, 0);
    check("rst busy", busy5, 0);
    check("rst done", done5, 0);
    check("rst overrun", ovr5, 0);
    rst_n = 1'b1;
    step();

    // ---------------- one-shot 10 samples ----------------
    for (int i = 0; i < 10; i++) load(aw'(i), dw'(100 * i));
    tready      = 1'b1;
    loop_en     = 1'b0;
    num_samples = 11'd10;
    start5      = 1'b1;
    step();
    start5 = 1'b0;
    check("t1 busy at start", busy5, 1);
    check("t1 tvalid at start", tvalid5, 0);
    for (int k = 0; k < 10; k++)
      expect_sample(1'b0, $sformatf("t1 s%0d", k), dw'(100 * k), k == 9, 5);
    step();
    check("t1 busy after last hs", busy5, 1);
    check("t1 done after last hs", done5, 0);
    check("t1 tvalid after last hs", tvalid5, 0);
    step();
    check("t1 done pulse", done5, 1);
    check("t1 busy low", busy5, 0);
    step();
    check("t1 done falls", done5, 0);
    check("t1 overrun", ovr5, 0);

    // ---------------- loop mode, then reset mid-stream ----------------
    loop_en = 1'b1;
    start5  = 1'b1;
    step();
    start5  = 1'b0;
    loop_en = 1'b0;
    for (int k = 0; k < 25; k++) begin
      expect_sample(1'b0, $sformatf("t2 s%0d", k), dw'(100 * (k % 10)), (k % 10) == 9, 5);
      check("t2 no done", done5, 0);
    end
    rst_n = 1'b0;
    #1;
    check("t2 rst tvalid", tvalid5, 0);
    check("t2 rst busy", busy5, 0);
    check("t2 rst tdata", tdata5, 0);
    check("t2 rst tlast", tlast5, 0);
    rst_n = 1'b1;
    step();

    // ---------------- backpressure ----------------
    tready      = 1'b0;
    num_samples = 11'd4;
    start5      = 1'b1;
    step();
    start5 = 1'b0;
    expect_sample(1'b0, "t3 s0", 16'd0, 1'b0, 5);
    for (int i = 0; i < 11; i++) begin
      step();
      check("t3 held tvalid", tvalid5, 1);
      check("t3 held tdata", tdata5, 0);
    end
    tready = 1'b1;
    step();
    check("t3 overrun", ovr5, 2);
    check("t3 tvalid after hs", tvalid5, 0);
    expect_sample(1'b0, "t3 s1", 16'd100, 1'b0, 3);
    expect_sample(1'b0, "t3 s2", 16'd200, 1'b0, 5);
    expect_sample(1'b0, "t3 s3", 16'd300, 1'b1, 5);
    step();
    step();
    check("t3 done", done5, 1);
    check("t3 overrun kept", ovr5, 2);

    // ---------------- illegal start lengths ----------------
    load(10'd0, 16'h8000);
    load(10'd1, 16'h7FFF);
    load(10'd2, 16'hFFFF);
    num_samples = 11'd0;
    start5      = 1'b1;
    step();
    start5 = 1'b0;
    check("t4 n0 busy", busy5, 0);
    step();
    check("t4 n0 tvalid", tvalid5, 0);
    num_samples = 11'd1025;
    start5      = 1'b1;
    step();
    start5 = 1'b0;
    check("t4 n1025 busy", busy5, 0);

    // ---------------- extremes, write during RUN ignored ----------------
    num_samples = 11'd3;
    start5      = 1'b1;
    step();
    start5 = 1'b0;
    check("t5 busy", busy5, 1);
    check("t5 overrun cleared", ovr5, 0);
    load(10'd2, 16'h1234);
    expect_sample(1'b0, "t5 s0", 16'h8000, 1'b0, 4);
    expect_sample(1'b0, "t5 s1", 16'h7FFF, 1'b0, 5);
    expect_sample(1'b0, "t5 s2", 16'hFFFF, 1'b1, 5);
    step();
    step();
    check("t5 done", done5, 1);

    // ---------------- full depth, clk_div=2, loop wrap ----------------
    wr_en = 1'b1;
    for (int i = 0; i < dep; i++) begin
      wr_addr = aw'(i);
      wr_data = dw'(i * 3 + 7);
      step();
    end
    wr_en       = 1'b0;
    num_samples = 11'd1024;
    loop_en     = 1'b1;
    start2      = 1'b1;
    step();
    start2 = 1'b0;
    check("t6 busy2", busy2, 1);
    check("t6 busy5 idle", busy5, 0);
    for (int k = 0; k < dep + 2; k++)
      expect_sample(1'b1, $sformatf("t6 s%0d", k), dw'((k % dep) * 3 + 7),
                    (k % dep) == (dep - 1), 2);
    check("t6 no done", done2, 0);
    check("t6 overrun", ovr2, 0);
    rst_n = 1'b0;
    #1;
    check("t6 rst tvalid", tvalid2, 0);
    check("t6 rst busy", busy2, 0);
    rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
